// File: rtl/noc_packet_arbiter.sv
// noc_packet_arbiter: round-robin arbiter merging N AXI-stream requesters
// onto one output; a grant is held from the first beat through TLAST.
module noc_packet_arbiter #(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_low,
  input  logic [N_PORTS-1:0]         port_en,
  input  logic [N_PORTS-1:0]         in_TVALID,
  input  logic [32*N_PORTS-1:0]      in_TDATA,
  input  logic [4*N_PORTS-1:0]       in_TKEEP,
  input  logic [N_PORTS-1:0]         in_TLAST,
  output logic [N_PORTS-1:0]         in_TREADY,
  output logic                       out_TVALID,
  output logic [31:0]                out_TDATA,
  output logic [3:0]                 out_TKEEP,
  output logic                       out_TLAST,
  input  logic                       out_TREADY,
  output logic [$clog2(N_PORTS)-1:0] grant_id,
  output logic                       busy,
  output logic [CNT_W-1:0]           pkt_count
);

  localparam int GW = $clog2(N_PORTS);
  localparam logic [GW:0] NP = (GW+1)'(N_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [N_PORTS-1:0] req, rot;
  logic [GW-1:0]    off, pick;
  logic [GW:0]      sum;
  logic             pick_vld, done;
  logic [31:0]      dat [N_PORTS];
  logic [3:0]       kep [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign dat[i] = in_TDATA[32*i +: 32];
    assign kep[i] = in_TKEEP[4*i +: 4];
  end

  assign req = in_TVALID & port_en;
  // rotate so bit 0 is the port at rr_q; lowest set bit wins
  assign rot = N_PORTS'({req, req} >> rr_q);

  always_comb begin
    off      = '0;
    pick_vld = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off      = GW'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign sum  = {1'b0, rr_q} + {1'b0, off};
  assign pick = (sum >= NP) ? GW'(sum - NP) : sum[GW-1:0];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    done       = 1'b0;
    out_TVALID = 1'b0;
    out_TDATA  = '0;
    out_TKEEP  = '0;
    out_TLAST  = 1'b0;
    in_TREADY  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        out_TVALID         = in_TVALID[grant_q];
        out_TDATA          = dat[grant_q];
        out_TKEEP          = kep[grant_q];
        out_TLAST          = in_TLAST[grant_q];
        in_TREADY[grant_q] = out_TREADY;
        if (out_TVALID && out_TREADY && out_TLAST) begin
          done    = 1'b1;
          state_d = IDLE;
          rr_d    = (grant_q == GW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_low) begin
    if (!rst_low) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      if (done) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign busy      = (state_q == BUSY);
  assign grant_id  = grant_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_noc_packet_arbiter.sv
// tb_noc_packet_arbiter: random and directed traffic against a queue-based
// reference model; a monitor scores every output beat.
`timescale 1ns/1ps
module tb_noc_packet_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct {
    int    port;
    beat_t b;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_low;
  logic [N-1:0]    port_en;
  logic [N-1:0]    in_TVALID;
  logic [32*N-1:0] in_TDATA;
  logic [4*N-1:0]  in_TKEEP;
  logic [N-1:0]    in_TLAST;
  logic [N-1:0]    in_TREADY;
  logic            out_TVALID;
  logic [31:0]     out_TDATA;
  logic [3:0]      out_TKEEP;
  logic            out_TLAST;
  logic            out_TREADY;
  logic [1:0]      grant_id;
  logic            busy;
  logic [CW-1:0]   pkt_count;

  int    total = 0;
  int    bad   = 0;
  beat_t src_q [N][$];
  beat_t exp_q [N][$];
  exp_t  sb [$];
  int    glog [$];
  bit    rnd_valid = 1'b0;
  int    rdy_mode  = 0;
  bit    tog       = 1'b0;
  bit    m_busy    = 1'b0;
  int    m_grant   = 0;
  int    m_rr      = 0;
  int    m_cnt     = 0;
  logic [N-1:0] m_req;
  logic [N-1:0] xfer;
  beat_t m_b;
  exp_t  mon_e;

  always #5 clk = ~clk;

  noc_packet_arbiter #(.N_PORTS(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_low(rst_low), .port_en(port_en),
    .in_TVALID(in_TVALID), .in_TDATA(in_TDATA), .in_TKEEP(in_TKEEP),
    .in_TLAST(in_TLAST), .in_TREADY(in_TREADY),
    .out_TVALID(out_TVALID), .out_TDATA(out_TDATA),
    .out_TKEEP(out_TKEEP), .out_TLAST(out_TLAST),
    .out_TREADY(out_TREADY), .grant_id(grant_id),
    .busy(busy), .pkt_count(pkt_count)
  );

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gl(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  function automatic int pending();
    int n = sb.size();
    for (int i = 0; i < N; i++) n += src_q[i].size() + exp_q[i].size();
    return n;
  endfunction

  task automatic add_pkt(input int port, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = $urandom;
      b.k = 4'($urandom);
      b.l = (j == len - 1);
      src_q[port].push_back(b);
      exp_q[port].push_back(b);
    end
  endtask

  // Reference: one idle decision cycle, then the granted packet beat by beat.
  always @(negedge clk) begin
    if (!rst_low) begin
      m_busy = 1'b0; m_grant = 0; m_rr = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) exp_q[i].delete();
      sb.delete();
      check("rst_out", {out_TVALID, in_TREADY, busy, grant_id, pkt_count}, '0);
    end else begin
      check("busy", 64'(busy), 64'(m_busy));
      check("grant_id", 64'(grant_id), 64'(m_grant));
      check("pkt_count", 64'(pkt_count), 64'(m_cnt % (1 << CW)));
      if (!m_busy) begin
        check("idle_out", {out_TVALID, in_TREADY}, '0);
        m_req = in_TVALID & port_en;
        for (int k = 0; k < N; k++) begin
          if (!m_busy && m_req[(m_rr + k) % N]) begin
            m_grant = (m_rr + k) % N;
            m_busy  = 1'b1;
          end
        end
      end else begin
        check("out_valid", 64'(out_TVALID), 64'(in_TVALID[m_grant]));
        check("in_ready", 64'(in_TREADY),
              out_TREADY ? (64'(1) << m_grant) : 64'(0));
        if (in_TVALID[m_grant] && out_TREADY) begin
          if (exp_q[m_grant].size() == 0) begin
            total++; bad++;
            $display("FAIL model_underrun: port %0d got beat want none", m_grant);
          end else begin
            m_b = exp_q[m_grant].pop_front();
            sb.push_back('{port: m_grant, b: m_b});
            if (m_b.l) begin
              m_busy = 1'b0;
              m_rr   = (m_grant + 1) % N;
              m_cnt++;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_low && out_TVALID && out_TREADY) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: got beat %h want none", out_TDATA);
      end else begin
        mon_e = sb.pop_front();
        check("beat_port", 64'(grant_id), 64'(mon_e.port));
        check("beat_data", {out_TDATA, out_TKEEP, out_TLAST}, mon_e.b);
        if (mon_e.b.l) glog.push_back(mon_e.port);
      end
    end
  end

  // Sources: present queue heads, pop on observed handshake.
  always begin
    @(negedge clk);
    xfer = in_TVALID & in_TREADY;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      if (src_q[i].size() > 0) begin
        in_TVALID[i] = !rnd_valid || ($urandom_range(0, 3) != 0);
        in_TDATA[32*i +: 32] = src_q[i][0].d;
        in_TKEEP[4*i +: 4]   = src_q[i][0].k;
        in_TLAST[i]          = src_q[i][0].l;
      end else begin
        in_TVALID[i] = 1'b0;
        in_TDATA[32*i +: 32] = $urandom;
        in_TLAST[i]          = 1'($urandom);
      end
    end
    case (rdy_mode)
      0: out_TREADY = 1'b1;
      1: begin tog = ~tog; out_TREADY = tog; end
      default: out_TREADY = 1'($urandom);
    endcase
  end

  task automatic drain(input int budget);
    int c = 0;
    while ((pending() != 0 || m_busy) && c < budget) begin
      @(posedge clk); #2; c++;
    end
    check("drain_done", 64'(c < budget), 64'(1));
  endtask

  task automatic wait_busy(input int g, input int budget);
    int c = 0;
    while (!(m_busy && (g < 0 || m_grant == g)) && c < budget) begin
      @(posedge clk); #2; c++;
    end
    check("busy_wait", 64'(c < budget), 64'(1));
  endtask

  task automatic do_reset();
    rst_low = 1'b0;
    #1;
    check("rst_imm", {out_TVALID, in_TREADY, busy, grant_id}, '0);
    for (int i = 0; i < N; i++) src_q[i].delete();
    in_TVALID = '0;
    glog.delete();
    repeat (2) @(posedge clk);
    #1 rst_low = 1'b1;
    @(posedge clk); #2;
    check("rst_state", {busy, grant_id, pkt_count}, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gs;
    rst_low = 1'b0; port_en = '0; in_TVALID = '0; in_TDATA = '0;
    in_TKEEP = '0; in_TLAST = '0; out_TREADY = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    do_reset();
    port_en = '1;

    // single requester, then rr pointer sits just past port 2
    add_pkt(2, 3);
    drain(50);
    check("single_grant", 64'(gl(0)), 64'(2));
    check("single_cnt", 64'(pkt_count), 64'(1));
    add_pkt(0, 1);
    add_pkt(3, 1);
    drain(50);
    check("rr_next", 64'(gl(1)), 64'(3));
    check("rr_wrap", 64'(gl(2)), 64'(0));

    // fairness from a fresh pointer, and 17 packets wrap a 4-bit count
    do_reset();
    for (int k = 0; k < 17; k++) add_pkt(k % N, 1);
    drain(200);
    for (int k = 0; k < 5; k++) check("fair_order", 64'(gl(k)), 64'(k % N));
    check("cnt_wrap", 64'(pkt_count), 64'(1));

    // backpressure on a 4-beat packet
    rdy_mode = 1;
    add_pkt(1, 4);
    drain(50);
    rdy_mode = 0;

    // enable masking with an in-flight port losing its enable
    gs = glog.size();
    port_en = 4'b1010;
    for (int p = 0; p < N; p++) begin add_pkt(p, 2); add_pkt(p, 2); end
    wait_busy(1, 100);
    port_en = 4'b1000;
    for (int c = 0; c < 200 && (m_busy || exp_q[3].size() != 0); c++) begin
      @(posedge clk); #2;
    end
    check("mask_p1_done", 64'(exp_q[1].size()), 64'(2));
    check("mask_p0_held", 64'(exp_q[0].size()), 64'(4));
    check("mask_p2_held", 64'(exp_q[2].size()), 64'(4));
    for (int i = gs; i < glog.size(); i++)
      check("mask_only13", 64'(glog[i] == 1 || glog[i] == 3), 64'(1));
    port_en = '1;
    drain(300);

    // reset in the middle of a packet
    add_pkt(2, 6);
    wait_busy(2, 50);
    @(posedge clk); #2;
    do_reset();
    add_pkt(3, 1);
    add_pkt(1, 1);
    drain(50);
    check("rst_first", 64'(gl(0)), 64'(1));
    check("rst_second", 64'(gl(1)), 64'(3));

    // random traffic, enables and backpressure
    rnd_valid = 1'b1;
    rdy_mode  = 2;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 3) == 0)
        add_pkt($urandom_range(0, N - 1), $urandom_range(1, 5));
      if ($urandom_range(0, 15) == 0) port_en = 4'($urandom_range(0, 15));
    end
    port_en = '1;
    drain(3000);
    check("sb_left", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
